// File: rtl/alu_pkg.sv
// alu_pkg: ALU function codes and datapath widths shared by the operand stage
package alu_pkg;
   localparam int ALU_DW   = 32;
   localparam int ALU_RAW  = 5;
   localparam int ALU_CNTW = 32;
   localparam logic [ALU_RAW-1:0] REG_ZERO = 5'd0;
   localparam logic [5:0] ALU_ADD = 6'b000000;
   localparam logic [5:0] ALU_SUB = 6'b000001;
   localparam logic [5:0] ALU_AND = 6'b011000;
   localparam logic [5:0] ALU_OR  = 6'b011110;
   localparam logic [5:0] ALU_XOR = 6'b010110;
   localparam logic [5:0] ALU_NOR = 6'b010001;
   localparam logic [5:0] ALU_SLL = 6'b100000;
   localparam logic [5:0] ALU_SRL = 6'b100001;
   localparam logic [5:0] ALU_SRA = 6'b100011;
   localparam logic [5:0] ALU_EQ  = 6'b110011;
   localparam logic [5:0] ALU_LT  = 6'b110101;
endpackage

// File: rtl/fwd_select.sv
// fwd_select: picks the newest in-flight value for one register operand
module fwd_select
   import alu_pkg::*;
#(
   parameter int DW  = ALU_DW,
   parameter int RAW = ALU_RAW
) (
   input  logic [RAW-1:0] addr,
   input  logic [DW-1:0]  raw,
   input  logic           exmem_regwrite,
   input  logic [RAW-1:0] exmem_rd,
   input  logic [DW-1:0]  exmem_result,
   input  logic           memwb_regwrite,
   input  logic [RAW-1:0] memwb_rd,
   input  logic [DW-1:0]  memwb_result,
   output logic [DW-1:0]  data
);
   logic ex_hit, wb_hit;
   always_comb begin
      ex_hit = exmem_regwrite && exmem_rd != '0 && exmem_rd == addr;
      wb_hit = memwb_regwrite && memwb_rd != '0 && memwb_rd == addr;
      data = ex_hit ? exmem_result : wb_hit ? memwb_result : raw;
   end
endmodule

// File: rtl/alu_operand_stage.sv
// alu_operand_stage: ID/EX register with operand forwarding and load-use bubble insertion
module alu_operand_stage
   import alu_pkg::*;
#(
   parameter int DW   = ALU_DW,
   parameter int RAW  = ALU_RAW,
   parameter int CNTW = ALU_CNTW
) (
   input  logic            clk,
   input  logic            reset,
   input  logic            id_valid,
   input  logic [RAW-1:0]  id_rs_addr,
   input  logic [RAW-1:0]  id_rt_addr,
   input  logic [DW-1:0]   id_rs_data,
   input  logic [DW-1:0]   id_rt_data,
   input  logic [4:0]      id_shamt,
   input  logic [DW-1:0]   id_imm32,
   input  logic            id_alusrc_a,
   input  logic            id_alusrc_b,
   input  logic [5:0]      id_alufun,
   input  logic [RAW-1:0]  id_rd_addr,
   input  logic            id_regwrite,
   input  logic            id_memread,
   input  logic            stall,
   input  logic            flush,
   input  logic            exmem_regwrite,
   input  logic [RAW-1:0]  exmem_rd,
   input  logic [DW-1:0]   exmem_result,
   input  logic            memwb_regwrite,
   input  logic [RAW-1:0]  memwb_rd,
   input  logic [DW-1:0]   memwb_result,
   output logic            ex_valid,
   output logic [DW-1:0]   ex_a,
   output logic [DW-1:0]   ex_b,
   output logic [5:0]      ex_alufun,
   output logic [RAW-1:0]  ex_rd,
   output logic            ex_regwrite,
   output logic            ex_memread,
   output logic            hazard_stall,
   output logic [CNTW-1:0] stall_count
);
   logic [RAW-1:0] r_rs_addr, r_rt_addr;
   logic [DW-1:0]  r_rs_data, r_rt_data, r_imm32, fwd_rs, fwd_rt;
   logic [4:0]     r_shamt;
   logic           r_alusrc_a, r_alusrc_b, r_regwrite;
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         ex_valid    <= 1'b0;
         r_regwrite  <= 1'b0;
         ex_memread  <= 1'b0;
         ex_rd       <= '0;
         ex_alufun   <= '0;
         r_rs_addr   <= '0;
         r_rt_addr   <= '0;
         r_rs_data   <= '0;
         r_rt_data   <= '0;
         r_imm32     <= '0;
         r_shamt     <= '0;
         r_alusrc_a  <= 1'b0;
         r_alusrc_b  <= 1'b0;
         stall_count <= '0;
      end else begin
         if (hazard_stall) stall_count <= stall_count + CNTW'(1);
         // hazard_stall is already masked by stall, so a bubble only lands when not held
         if (flush || hazard_stall) begin
            ex_valid   <= 1'b0;
            r_regwrite <= 1'b0;
            ex_memread <= 1'b0;
         end else if (!stall) begin
            ex_valid   <= id_valid;
            r_regwrite <= id_regwrite;
            ex_memread <= id_memread;
            ex_rd      <= id_rd_addr;
            ex_alufun  <= id_alufun;
            r_rs_addr  <= id_rs_addr;
            r_rt_addr  <= id_rt_addr;
            r_rs_data  <= id_rs_data;
            r_rt_data  <= id_rt_data;
            r_imm32    <= id_imm32;
            r_shamt    <= id_shamt;
            r_alusrc_a <= id_alusrc_a;
            r_alusrc_b <= id_alusrc_b;
         end
      end
   end
   fwd_select #(.DW(DW), .RAW(RAW)) u_fwd_rs (
      .addr(r_rs_addr), .raw(r_rs_data),
      .exmem_regwrite(exmem_regwrite), .exmem_rd(exmem_rd), .exmem_result(exmem_result),
      .memwb_regwrite(memwb_regwrite), .memwb_rd(memwb_rd), .memwb_result(memwb_result),
      .data(fwd_rs)
   );
   fwd_select #(.DW(DW), .RAW(RAW)) u_fwd_rt (
      .addr(r_rt_addr), .raw(r_rt_data),
      .exmem_regwrite(exmem_regwrite), .exmem_rd(exmem_rd), .exmem_result(exmem_result),
      .memwb_regwrite(memwb_regwrite), .memwb_rd(memwb_rd), .memwb_result(memwb_result),
      .data(fwd_rt)
   );
   // shift-by-immediate does not read rs, so only rt can create a load-use dependency then
   always_comb begin
      hazard_stall = !flush && !stall && id_valid && ex_valid && ex_memread && ex_rd != '0 &&
                     ((ex_rd == id_rs_addr && !id_alusrc_a) || ex_rd == id_rt_addr);
      ex_a = r_alusrc_a ? DW'(r_shamt) : fwd_rs;
      ex_b = r_alusrc_b ? r_imm32 : fwd_rt;
      ex_regwrite = ex_valid && r_regwrite;
   end
endmodule

// File: tb/tb_alu_operand_stage.sv
// tb_alu_operand_stage: directed vector table, corner sequences and a randomized model comparison
module tb_alu_operand_stage;
   import alu_pkg::*;
   logic clk = 1'b0, reset = 1'b0;
   logic id_valid, id_alusrc_a, id_alusrc_b, id_regwrite, id_memread, stall, flush;
   logic [4:0] id_rs_addr, id_rt_addr, id_shamt, id_rd_addr, exmem_rd, memwb_rd, ex_rd;
   logic [31:0] id_rs_data, id_rt_data, id_imm32, exmem_result, memwb_result, ex_a, ex_b, stall_count;
   logic [5:0] id_alufun, ex_alufun;
   logic exmem_regwrite, memwb_regwrite, ex_valid, ex_regwrite, ex_memread, hazard_stall;
   int checks = 0, errors = 0;

   alu_operand_stage dut (
      .clk(clk), .reset(reset), .id_valid(id_valid), .id_rs_addr(id_rs_addr), .id_rt_addr(id_rt_addr),
      .id_rs_data(id_rs_data), .id_rt_data(id_rt_data), .id_shamt(id_shamt), .id_imm32(id_imm32),
      .id_alusrc_a(id_alusrc_a), .id_alusrc_b(id_alusrc_b), .id_alufun(id_alufun), .id_rd_addr(id_rd_addr),
      .id_regwrite(id_regwrite), .id_memread(id_memread), .stall(stall), .flush(flush),
      .exmem_regwrite(exmem_regwrite), .exmem_rd(exmem_rd), .exmem_result(exmem_result),
      .memwb_regwrite(memwb_regwrite), .memwb_rd(memwb_rd), .memwb_result(memwb_result),
      .ex_valid(ex_valid), .ex_a(ex_a), .ex_b(ex_b), .ex_alufun(ex_alufun), .ex_rd(ex_rd),
      .ex_regwrite(ex_regwrite), .ex_memread(ex_memread), .hazard_stall(hazard_stall),
      .stall_count(stall_count)
   );

   always #5 clk = ~clk;

   typedef struct {
      logic v, sa, sb, rw, mr;
      logic [4:0] rs, rt, shamt, rd;
      logic [31:0] rsd, rtd, imm;
      logic [5:0] fun;
   } ex_t;
   ex_t m;
   logic [31:0] cnt;

   typedef struct {
      logic [4:0] rs, rt, shamt;
      logic [31:0] rsd, rtd, imm;
      logic sa, sb;
      logic [5:0] fun;
      logic xw; logic [4:0] xrd; logic [31:0] xres;
      logic ww; logic [4:0] wrd; logic [31:0] wres;
      logic [31:0] ea, eb;
   } vec_t;
   vec_t tbl[6];

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
      end
   endtask

   task automatic idle();
      id_valid = 0; id_alusrc_a = 0; id_alusrc_b = 0; id_regwrite = 0; id_memread = 0;
      id_rs_addr = 0; id_rt_addr = 0; id_shamt = 0; id_rd_addr = 0; id_alufun = 0;
      id_rs_data = 0; id_rt_data = 0; id_imm32 = 0; stall = 0; flush = 0;
      exmem_regwrite = 0; exmem_rd = 0; exmem_result = 0;
      memwb_regwrite = 0; memwb_rd = 0; memwb_result = 0;
   endtask

   task automatic do_reset();
      idle();
      reset = 1;
      #2;
      @(negedge clk);
      reset = 0;
      m = '{default: '0};
      cnt = 0;
   endtask

   task automatic drive_id(input logic [4:0] rs, input logic [4:0] rt, input logic [31:0] rsd,
                           input logic [31:0] rtd, input logic [5:0] fun, input logic [4:0] rd,
                           input logic rw, input logic mr);
      id_valid = 1; id_rs_addr = rs; id_rt_addr = rt; id_rs_data = rsd; id_rt_data = rtd;
      id_alufun = fun; id_rd_addr = rd; id_regwrite = rw; id_memread = mr;
   endtask

   function automatic logic [31:0] fwd(input logic [4:0] a, input logic [31:0] raw);
      if (a != 0 && exmem_regwrite && exmem_rd == a) return exmem_result;
      if (a != 0 && memwb_regwrite && memwb_rd == a) return memwb_result;
      return raw;
   endfunction

   function automatic logic exp_haz();
      return !stall && !flush && id_valid && m.v && m.mr && m.rd != 0 &&
             ((m.rd == id_rs_addr && !id_alusrc_a) || m.rd == id_rt_addr);
   endfunction

   task automatic check_model();
      chk("rnd_valid", ex_valid, m.v);
      chk("rnd_regwrite", ex_regwrite, m.v & m.rw);
      chk("rnd_memread", ex_memread, m.mr);
      chk("rnd_rd", ex_rd, m.rd);
      chk("rnd_hazard", hazard_stall, exp_haz());
      chk("rnd_count", stall_count, cnt);
      if (m.v) begin
         chk("rnd_a", ex_a, m.sa ? {27'b0, m.shamt} : fwd(m.rs, m.rsd));
         chk("rnd_b", ex_b, m.sb ? m.imm : fwd(m.rt, m.rtd));
         chk("rnd_alufun", ex_alufun, m.fun);
      end
   endtask

   task automatic step_model();
      logic h;
      h = exp_haz();
      if (h) cnt = cnt + 1;
      if (flush || h) begin
         m.v = 0; m.rw = 0; m.mr = 0;
      end else if (!stall) begin
         m = '{v: id_valid, sa: id_alusrc_a, sb: id_alusrc_b, rw: id_regwrite, mr: id_memread,
               rs: id_rs_addr, rt: id_rt_addr, shamt: id_shamt, rd: id_rd_addr,
               rsd: id_rs_data, rtd: id_rt_data, imm: id_imm32, fun: id_alufun};
      end
   endtask

   initial begin
      tbl[0] = '{5'd5, 5'd6, 5'd4, 32'd77, 32'hFFFFFFFF, 32'h0, 1'b1, 1'b0, ALU_SLL,
                 1'b0, 5'd0, 32'h0, 1'b0, 5'd0, 32'h0, 32'h4, 32'hFFFFFFFF};
      tbl[1] = '{5'd8, 5'd8, 5'd0, 32'h1, 32'h2, 32'h0, 1'b0, 1'b0, ALU_ADD,
                 1'b1, 5'd8, 32'h11, 1'b1, 5'd8, 32'h22, 32'h11, 32'h11};
      tbl[2] = '{5'd8, 5'd8, 5'd0, 32'h1, 32'h2, 32'h0, 1'b0, 1'b0, ALU_ADD,
                 1'b0, 5'd8, 32'h11, 1'b1, 5'd8, 32'h22, 32'h22, 32'h22};
      tbl[3] = '{5'd0, 5'd3, 5'd0, 32'h0, 32'h5, 32'h0, 1'b0, 1'b0, ALU_OR,
                 1'b1, 5'd0, 32'hDEAD, 1'b1, 5'd0, 32'hBEEF, 32'h0, 32'h5};
      tbl[4] = '{5'd4, 5'd7, 5'd0, 32'd10, 32'd20, 32'h1234, 1'b0, 1'b1, ALU_SUB,
                 1'b1, 5'd7, 32'hAA, 1'b1, 5'd4, 32'hBB, 32'hBB, 32'h1234};
      tbl[5] = '{5'd2, 5'd9, 5'd31, 32'h7, 32'h3, 32'h0, 1'b1, 1'b0, ALU_SRA,
                 1'b1, 5'd2, 32'hCC, 1'b1, 5'd9, 32'hDD, 32'h1F, 32'hDD};
      do_reset();
      chk("reset_valid", ex_valid, 0);
      chk("reset_alufun", ex_alufun, 0);
      chk("reset_count", stall_count, 0);
      chk("reset_regwrite", ex_regwrite, 0);

      for (int i = 0; i < 6; i++) begin
         @(negedge clk);
         idle();
         drive_id(tbl[i].rs, tbl[i].rt, tbl[i].rsd, tbl[i].rtd, tbl[i].fun, 5'd1, 1'b1, 1'b0);
         id_shamt = tbl[i].shamt; id_imm32 = tbl[i].imm;
         id_alusrc_a = tbl[i].sa; id_alusrc_b = tbl[i].sb;
         @(posedge clk);
         #1;
         exmem_regwrite = tbl[i].xw; exmem_rd = tbl[i].xrd; exmem_result = tbl[i].xres;
         memwb_regwrite = tbl[i].ww; memwb_rd = tbl[i].wrd; memwb_result = tbl[i].wres;
         #1;
         chk($sformatf("vec%0d_a", i), ex_a, tbl[i].ea);
         chk($sformatf("vec%0d_b", i), ex_b, tbl[i].eb);
         chk($sformatf("vec%0d_alufun", i), ex_alufun, tbl[i].fun);
         chk($sformatf("vec%0d_valid", i), ex_valid, 1);
      end

      do_reset();
      drive_id(5'd1, 5'd0, 32'h0, 32'h0, ALU_ADD, 5'd9, 1'b1, 1'b1);
      id_alusrc_b = 1; id_imm32 = 32'h4;
      @(posedge clk);
      @(negedge clk);
      idle();
      drive_id(5'd0, 5'd9, 32'h0, 32'h1234, ALU_SRA, 5'd10, 1'b1, 1'b0);
      id_alusrc_a = 1; id_shamt = 5'd2;
      #1;
      chk("lu_hazard", hazard_stall, 1);
      chk("lu_count0", stall_count, 0);
      @(posedge clk);
      #1;
      chk("lu_bubble_valid", ex_valid, 0);
      chk("lu_bubble_regwrite", ex_regwrite, 0);
      chk("lu_count1", stall_count, 1);
      chk("lu_hazard_clear", hazard_stall, 0);
      exmem_regwrite = 1; exmem_rd = 5'd9; exmem_result = 32'h5555;
      @(posedge clk);
      #1;
      exmem_regwrite = 0;
      memwb_regwrite = 1; memwb_rd = 5'd9; memwb_result = 32'h80000000;
      #1;
      chk("lu_reissue_valid", ex_valid, 1);
      chk("lu_reissue_a", ex_a, 32'h2);
      chk("lu_reissue_b", ex_b, 32'h80000000);
      chk("lu_reissue_alufun", ex_alufun, ALU_SRA);
      chk("lu_reissue_rd", ex_rd, 10);
      chk("lu_count_hold", stall_count, 1);

      do_reset();
      drive_id(5'd1, 5'd2, 32'hAAAA, 32'hBBBB, ALU_ADD, 5'd3, 1'b1, 1'b0);
      @(posedge clk);
      for (int i = 0; i < 3; i++) begin
         @(negedge clk);
         stall = 1;
         drive_id(5'(i + 4), 5'(i + 5), $urandom, $urandom, ALU_XOR, 5'(i + 6), 1'b0, 1'b1);
         #1;
         chk("stall_hazard", hazard_stall, 0);
         @(posedge clk);
         #1;
         chk("stall_a", ex_a, 32'hAAAA);
         chk("stall_b", ex_b, 32'hBBBB);
         chk("stall_rd", ex_rd, 3);
         chk("stall_alufun", ex_alufun, ALU_ADD);
         chk("stall_memread", ex_memread, 0);
         chk("stall_regwrite", ex_regwrite, 1);
      end
      @(negedge clk);
      idle();
      drive_id(5'd1, 5'd0, 32'h0, 32'h0, ALU_ADD, 5'd9, 1'b1, 1'b1);
      @(posedge clk);
      @(negedge clk);
      idle();
      drive_id(5'd9, 5'd0, 32'h0, 32'h0, ALU_ADD, 5'd4, 1'b1, 1'b0);
      #1;
      chk("fh_hazard_pre", hazard_stall, 1);
      flush = 1;
      #1;
      chk("fh_hazard_gated", hazard_stall, 0);
      @(posedge clk);
      #1;
      chk("fh_valid", ex_valid, 0);
      chk("fh_memread", ex_memread, 0);
      chk("fh_count", stall_count, 0);

      @(negedge clk);
      idle();
      drive_id(5'd1, 5'd0, 32'h0, 32'h0, ALU_ADD, 5'd9, 1'b1, 1'b1);
      @(posedge clk);
      @(negedge clk);
      idle();
      drive_id(5'd9, 5'd0, 32'h0, 32'h0, ALU_ADD, 5'd4, 1'b1, 1'b0);
      @(posedge clk);
      @(negedge clk);
      idle();
      drive_id(5'd3, 5'd4, 32'h77, 32'h88, ALU_SLL, 5'd5, 1'b1, 1'b1);
      @(posedge clk);
      #1;
      chk("ar_pre_valid", ex_valid, 1);
      chk("ar_pre_count", stall_count, 1);
      #2;
      reset = 1;
      #1;
      chk("ar_valid", ex_valid, 0);
      chk("ar_alufun", ex_alufun, 0);
      chk("ar_rd", ex_rd, 0);
      chk("ar_regwrite", ex_regwrite, 0);
      chk("ar_memread", ex_memread, 0);
      chk("ar_count", stall_count, 0);
      chk("ar_a", ex_a, 0);
      chk("ar_b", ex_b, 0);

      do_reset();
      for (int c = 0; c < 400; c++) begin
         @(negedge clk);
         id_valid = $urandom_range(0, 9) < 8;
         id_rs_addr = 5'($urandom_range(0, 3));
         id_rt_addr = 5'($urandom_range(0, 3));
         id_rd_addr = 5'($urandom_range(0, 3));
         id_rs_data = $urandom; id_rt_data = $urandom; id_imm32 = $urandom;
         id_shamt = 5'($urandom);
         id_alufun = 6'($urandom);
         id_alusrc_a = $urandom_range(0, 3) == 0;
         id_alusrc_b = $urandom_range(0, 3) == 0;
         id_regwrite = $urandom_range(0, 1) == 1;
         id_memread = $urandom_range(0, 9) < 4;
         stall = $urandom_range(0, 99) < 15;
         flush = $urandom_range(0, 99) < 10;
         exmem_regwrite = $urandom_range(0, 1) == 1;
         exmem_rd = 5'($urandom_range(0, 3));
         exmem_result = $urandom;
         memwb_regwrite = $urandom_range(0, 1) == 1;
         memwb_rd = 5'($urandom_range(0, 3));
         memwb_result = $urandom;
         #1;
         check_model();
         step_model();
      end
      @(negedge clk);
      chk("rnd_final_count", stall_count, cnt);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end
endmodule
